// File: rtl/dbg_pkg.sv
// Shared debug-link definitions: word-assembler state encoding, default byte width
// and the bytes-per-word helper.
package dbg_pkg;

    localparam int DBG_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } dbg_state_e;

    function automatic int dbg_nbytes(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/dbg_idle_timer.sv
// Idle-cycle counter for the word assembler: counts while run is high, clears on
// clear, and flags the cycle in which the count reaches LIMIT.
module dbg_idle_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tc
);

    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] count_r;

    assign tc = run && (count_r == LIMIT_C);

    // Idle counter; restarts whenever the assembler leaves COLLECT or takes a byte
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (!run || clear || tc) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/debug_word_assembler.sv
// Collects debug-link bytes into one word of up to DATA_W bits with selectable count
// and byte order. Optional inter-byte idle timeout enabled by DBG_ASM_TIMEOUT_EN.
module debug_word_assembler
    import dbg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int BYTE_W  = DBG_BYTE_W,
    parameter int TIMEOUT = 255,
    localparam int NB     = dbg_nbytes(DATA_W, BYTE_W),
    localparam int SZ_W   = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] code,
    input  logic              code_valid,
    input  logic [SZ_W-1:0]   size,
    input  logic              msb_first,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    localparam logic [SZ_W-1:0] LAST_IDX = SZ_W'(NB - 1);

    if (((DATA_W % BYTE_W) != 0) || (TIMEOUT < 1)) begin : g_param_check
        $error("debug_word_assembler: DATA_W must be a multiple of BYTE_W and TIMEOUT >= 1");
    end

    dbg_state_e        state_r, state_nxt_s;
    logic [SZ_W-1:0]   cnt_r, cnt_nxt_s;
    logic [SZ_W-1:0]   last_idx_r, last_idx_s, eff_size_s, idx_s, lane_s;
    logic              msb_r, msb_s;
    logic [DATA_W-1:0] result_r, result_nxt_s;
    logic              result_valid_r, busy_r, overrun_r, timeout_err_r;
    logic              accept_s, first_s, done_s, idle_tc_s, timeout_s, overrun_s;

`ifdef DBG_ASM_TIMEOUT_EN
    dbg_idle_timer #(
        .LIMIT (TIMEOUT)
    ) u_idle_timer (
        .clk   (clk),
        .reset (reset),
        .run   (state_r == COLLECT),
        .clear (accept_s),
        .tc    (idle_tc_s)
    );
`else
    assign idle_tc_s = 1'b0;
`endif

    // Byte acceptance, word-geometry selection and lane placement
    always_comb begin
        accept_s   = code_valid && ((state_r != HOLD) || result_ready);
        timeout_s  = (state_r == COLLECT) && idle_tc_s;
        // A timed-out partial word is dropped, so a byte in that cycle starts afresh
        first_s    = (state_r != COLLECT) || timeout_s;
        overrun_s  = code_valid && (state_r == HOLD) && !result_ready;
        eff_size_s = (size > LAST_IDX) ? LAST_IDX : size;
        if (first_s) begin
            idx_s      = {SZ_W{1'b0}};
            last_idx_s = eff_size_s;
            msb_s      = msb_first;
        end else begin
            idx_s      = cnt_r;
            last_idx_s = last_idx_r;
            msb_s      = msb_r;
        end
        done_s = accept_s && (idx_s == last_idx_s);
        lane_s = msb_s ? (last_idx_s - idx_s) : idx_s;
        result_nxt_s = first_s ? {DATA_W{1'b0}} : result_r;
        for (int i = 0; i < NB; i++) begin
            if (lane_s == SZ_W'(i)) begin
                result_nxt_s[i*BYTE_W +: BYTE_W] = code;
            end else begin
                result_nxt_s[i*BYTE_W +: BYTE_W] = result_nxt_s[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Next-state and byte-counter selection
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (done_s) begin
            state_nxt_s = HOLD;
            cnt_nxt_s   = {SZ_W{1'b0}};
        end else if (accept_s) begin
            state_nxt_s = COLLECT;
            cnt_nxt_s   = idx_s + {{(SZ_W-1){1'b0}}, 1'b1};
        end else if (timeout_s) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {SZ_W{1'b0}};
        end else begin
            case (state_r)
                HOLD:    state_nxt_s = result_ready ? IDLE : HOLD;
                COLLECT: state_nxt_s = COLLECT;
                IDLE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State, word storage and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            cnt_r          <= {SZ_W{1'b0}};
            last_idx_r     <= {SZ_W{1'b0}};
            msb_r          <= 1'b0;
            result_r       <= {DATA_W{1'b0}};
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            overrun_r      <= 1'b0;
            timeout_err_r  <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            if (accept_s) begin
                result_r   <= result_nxt_s;
                last_idx_r <= last_idx_s;
                msb_r      <= msb_s;
            end
            result_valid_r <= (state_nxt_s == HOLD);
            busy_r         <= (state_nxt_s == COLLECT);
            overrun_r      <= overrun_s;
            timeout_err_r  <= timeout_s;
        end
    end

    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign busy         = busy_r;
    assign overrun      = overrun_r;
    assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_debug_word_assembler.sv
// Directed self-checking bench for debug_word_assembler (32-bit words, 8-bit bytes).
module tb_debug_word_assembler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  code = 8'h00;
    logic        code_valid = 1'b0;
    logic [1:0]  size = 2'd0;
    logic        msb_first = 1'b0;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready = 1'b1;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    int tests_run = 0;
    int tests_failed = 0;

    debug_word_assembler #(
        .DATA_W  (32),
        .BYTE_W  (8),
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .code         (code),
        .code_valid   (code_valid),
        .size         (size),
        .msb_first    (msb_first),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        code       = b;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({result, result_valid, busy, overrun, timeout_err} !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got result=%h v=%b busy=%b ovr=%b to=%b, want all 0",
                     result, result_valid, busy, overrun, timeout_err);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lsb_first();
        result_ready = 1'b1; size = 2'd3; msb_first = 1'b0;
        put(8'h3F);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++; $display("FAIL t1_busy: got %b want 1", busy);
        end
        put(8'h38); put(8'h3F);
        tests_run++;
        if (result_valid !== 1'b0) begin
            tests_failed++; $display("FAIL t1_early_valid: got %b want 0", result_valid);
        end
        put(8'h38);
        tests_run++;
        if (result_valid !== 1'b1 || result !== 32'h383F383F) begin
            tests_failed++; $display("FAIL t1_word: got v=%b %h want v=1 383f383f", result_valid, result);
        end
        tick();
        tests_run++;
        if (result_valid !== 1'b0) begin
            tests_failed++; $display("FAIL t1_valid_drop: got %b want 0", result_valid);
        end
    endtask

    task automatic test_msb_first();
        size = 2'd3; msb_first = 1'b1;
        put(8'h3F); put(8'h38); put(8'h3F); put(8'h38);
        tests_run++;
        if (result_valid !== 1'b1 || result !== 32'h3F383F38) begin
            tests_failed++; $display("FAIL t2_word: got v=%b %h want v=1 3f383f38", result_valid, result);
        end
        msb_first = 1'b0;
        tick();
    endtask

    task automatic test_short_words();
        size = 2'd1;
        put(8'hAA); put(8'h55);
        tests_run++;
        if (result_valid !== 1'b1 || result !== 32'h000055AA) begin
            tests_failed++; $display("FAIL t3_two_byte: got v=%b %h want v=1 000055aa", result_valid, result);
        end
        tick();
        size = 2'd0;
        put(8'h7E);
        tests_run++;
        if (result_valid !== 1'b1 || result !== 32'h0000007E || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL t3_one_byte: got v=%b %h busy=%b want v=1 0000007e busy=0", result_valid, result, busy);
        end
        tick();
    endtask

    task automatic test_size_latched();
        size = 2'd1; msb_first = 1'b0;
        put(8'hA1);
        size = 2'd3; msb_first = 1'b1;
        put(8'hB2);
        tests_run++;
        if (result_valid !== 1'b1 || result !== 32'h0000B2A1) begin
            tests_failed++; $display("FAIL latch_word: got v=%b %h want v=1 0000b2a1", result_valid, result);
        end
        msb_first = 1'b0;
        tick();
    endtask

    task automatic test_overrun();
        result_ready = 1'b0; size = 2'd0;
        put(8'h33);
        put(8'h11);
        tests_run++;
        if (overrun !== 1'b1 || result !== 32'h00000033 || result_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL t4_overrun: got ovr=%b %h v=%b want ovr=1 00000033 v=1", overrun, result, result_valid);
        end
        tick();
        tests_run++;
        if (overrun !== 1'b0 || result !== 32'h00000033) begin
            tests_failed++; $display("FAIL t4_pulse_once: got ovr=%b %h want ovr=0 00000033", overrun, result);
        end
        result_ready = 1'b1;
        put(8'h22);
        tests_run++;
        if (result_valid !== 1'b1 || result !== 32'h00000022 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_back_to_back: got v=%b %h ovr=%b want v=1 00000022 ovr=0", result_valid, result, overrun);
        end
        tick();
        tests_run++;
        if (result_valid !== 1'b0) begin
            tests_failed++; $display("FAIL t4_drain: got %b want 0", result_valid);
        end
    endtask

    task automatic test_midword_reset();
        size = 2'd3; msb_first = 1'b0;
        put(8'h01); put(8'h02);
        reset = 1'b1;
        tick();
        tests_run++;
        if ({result, result_valid, busy, overrun, timeout_err} !== 36'h0) begin
            tests_failed++;
            $display("FAIL t5_reset: got result=%h v=%b busy=%b ovr=%b to=%b want all 0",
                     result, result_valid, busy, overrun, timeout_err);
        end
        reset = 1'b0;
        put(8'h01); put(8'h02); put(8'h03); put(8'h04);
        tests_run++;
        if (result_valid !== 1'b1 || result !== 32'h04030201) begin
            tests_failed++; $display("FAIL t5_fresh_word: got v=%b %h want v=1 04030201", result_valid, result);
        end
        tick();
    endtask

    task automatic test_timeout();
        size = 2'd3; msb_first = 1'b0;
        put(8'h5A);
`ifdef DBG_ASM_TIMEOUT_EN
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i < 9) begin
                tests_run++;
                if (timeout_err !== 1'b0 || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL t6_early_%0d: got to=%b busy=%b want to=0 busy=1", i, timeout_err, busy);
                end
            end else begin
                tests_run++;
                if (timeout_err !== 1'b1 || busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL t6_fire: got to=%b busy=%b want to=1 busy=0", timeout_err, busy);
                end
            end
        end
        tick();
        tests_run++;
        if (timeout_err !== 1'b0) begin
            tests_failed++; $display("FAIL t6_pulse: got %b want 0", timeout_err);
        end
        put(8'h0A); put(8'h0B); put(8'h0C); put(8'h0D);
        tests_run++;
        if (result_valid !== 1'b1 || result !== 32'h0D0C0B0A) begin
            tests_failed++; $display("FAIL t6_word: got v=%b %h want v=1 0d0c0b0a", result_valid, result);
        end
`else
        for (int i = 1; i <= 12; i++) begin
            tick();
            tests_run++;
            if (timeout_err !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL t6_wait_%0d: got to=%b busy=%b want to=0 busy=1", i, timeout_err, busy);
            end
        end
        put(8'h6B); put(8'h7C); put(8'h8D);
        tests_run++;
        if (result_valid !== 1'b1 || result !== 32'h8D7C6B5A) begin
            tests_failed++; $display("FAIL t6_word: got v=%b %h want v=1 8d7c6b5a", result_valid, result);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_short_words();
        test_size_latched();
        test_overrun();
        test_midword_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
